des_key_schedule_rev: RTL

- Sequential DES key-schedule generator. It accepts a 64-bit key and streams the 16 48-bit round subkeys one per handshake.
- Order is selectable: forward (K1..K16, left rotations) for the encrypt datapath, or reverse (K16..K1, right rotations) for the decrypt datapath.
- Applies PC-1, performs per-round C/D rotation, and applies standard PC-2 internally.
- Sits between the key register and the UART-side DES round engine.

---
 rtl/des_key_schedule_rev.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/des_key_schedule_rev.sv
// DES key schedule: PC-1 at load, per-round C/D rotation, PC-2 to stream 16 subkeys (forward K1..K16 or reverse K16..K1).
// Latency: first subkey valid one cycle after the load edge, then one subkey per accepted handshake with no bubbles.
// Backpressure: SUBKEY/ROUND/C-D hold while SUBKEY_VALID && !SUBKEY_READY; KEY_LOAD is only honoured in IDLE.
module des_key_schedule_rev #(
    parameter int unsigned PARITY_CHECK = 0
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [63:0] KEY_IN,
    input  logic        KEY_LOAD,
    input  logic        MODE,
    output logic [47:0] SUBKEY,
    output logic        SUBKEY_VALID,
    input  logic        SUBKEY_READY,
    output logic [3:0]  ROUND,
    output logic        BUSY,
    output logic        SCHED_DONE,
    output logic        KEY_PARITY_ERR
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    // FIPS 1-based bit positions; bit n of a W-bit vector lives at index W-n.
    localparam int PC1_TBL [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_TBL [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    function automatic logic [55:0] f_pc1(input logic [63:0] k);
        logic [55:0] o;
        o = '0;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_TBL[i]];
        return o;
    endfunction

    function automatic logic [47:0] f_pc2(input logic [55:0] cd);
        logic [47:0] o;
        o = '0;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_TBL[i]];
        return o;
    endfunction

    // Shift-table entry for 0-based round index: rounds 1, 2, 9 and 16 shift by one, the rest by two.
    function automatic logic f_shift_two(input logic [3:0] idx);
        return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
    endfunction

    // Rotate C (bits 1..28) and D (bits 29..56) independently by one or two places.
    function automatic logic [55:0] f_rot(input logic [55:0] cd, input logic left, input logic two);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (left) begin
            c = two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
            d = two ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
        end else begin
            c = two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
            d = two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
        end
        return {c, d};
    endfunction

    state_t      r_state;
    logic [55:0] r_cd;
    logic [47:0] r_subkey;
    logic [3:0]  r_round;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_par_err;
    logic        r_mode;

    logic [55:0] w_cd0;
    logic [55:0] w_load_cd;
    logic [55:0] w_step_cd;
    logic [3:0]  w_fwd_idx;
    logic        w_last;
    logic        w_hs;
    logic        w_par_err;

    assign w_cd0     = f_pc1(KEY_IN);
    // Reverse starts from CD16, which equals CD0 because the shifts total 28.
    assign w_load_cd = MODE ? w_cd0 : f_rot(w_cd0, 1'b1, 1'b0);
    // Forward applies the next round's shift; reverse undoes the shift of the round just presented.
    assign w_fwd_idx = r_round + 4'd1;
    assign w_step_cd = r_mode ? f_rot(r_cd, 1'b0, f_shift_two(r_round))
                              : f_rot(r_cd, 1'b1, f_shift_two(w_fwd_idx));
    assign w_last    = r_mode ? (r_round == 4'd0) : (r_round == 4'd15);
    assign w_hs      = r_valid & SUBKEY_READY;

    // A byte with even parity flags the key; disabled builds tie the flag low.
    always_comb begin
        w_par_err = 1'b0;
        if (PARITY_CHECK != 0) begin
            for (int b = 0; b < 8; b++) begin
                if (^KEY_IN[b*8 +: 8] == 1'b0) w_par_err = 1'b1;
            end
        end
    end

    // Schedule FSM: load in IDLE, advance one round per handshake in ACTIVE, pulse done after the last one.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_cd      <= '0;
            r_subkey  <= '0;
            r_round   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_par_err <= 1'b0;
            r_mode    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (KEY_LOAD) begin
                        r_cd      <= w_load_cd;
                        r_subkey  <= f_pc2(w_load_cd);
                        r_round   <= MODE ? 4'd15 : 4'd0;
                        r_mode    <= MODE;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_par_err <= w_par_err;
                        r_state   <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cd     <= w_step_cd;
                            r_subkey <= f_pc2(w_step_cd);
                            r_round  <= r_mode ? (r_round - 4'd1) : (r_round + 4'd1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign SUBKEY         = r_subkey;
    assign SUBKEY_VALID   = r_valid;
    assign ROUND          = r_round;
    assign BUSY           = r_busy;
    assign SCHED_DONE     = r_done;
    assign KEY_PARITY_ERR = r_par_err;

endmodule
